// File: rtl/gray_step_checker_if.sv
// Word/result bundle between a Gray source and the step checker.
// The master drives Gray words and clear; the slave (checker) returns decoded results.
interface gray_step_checker_if #(
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 valid_in;
  logic                 g0_in;
  logic                 g1_in;
  logic                 g2_in;
  logic                 clear_in;
  logic                 b0_out;
  logic                 b1_out;
  logic                 b2_out;
  logic                 valid_out;
  logic                 up_out;
  logic                 down_out;
  logic                 err_out;
  logic [ERR_CNT_W-1:0] err_cnt_out;
  logic                 locked_out;

  modport master (
    output valid_in, g0_in, g1_in, g2_in, clear_in,
    input  b0_out, b1_out, b2_out, valid_out, up_out, down_out, err_out, err_cnt_out,
           locked_out
  );

  modport slave (
    input  valid_in, g0_in, g1_in, g2_in, clear_in,
    output b0_out, b1_out, b2_out, valid_out, up_out, down_out, err_out, err_cnt_out,
           locked_out
  );
endinterface

// File: rtl/gray_step_checker.sv
// Decodes a 3-bit Gray stream, classifies each step against the previous word as
// up/down/repeat/illegal, counts illegal steps and tracks lock on the stream.
module gray_step_checker #(
  parameter int unsigned ERR_CNT_W = 8,
  parameter int unsigned LOCK_LOSS = 3
) (
  input logic                clk_in,
  input logic                rst_in,
  gray_step_checker_if.slave bus
);

  typedef enum logic {StIdle, StTrack} state_e;

  localparam logic [3:0]           LockLoss = 4'(LOCK_LOSS);
  localparam logic [ERR_CNT_W-1:0] CntMax   = '1;

  state_e               state_q, state_d;
  logic [2:0]           ref_q, ref_d;
  logic [3:0]           consec_q, consec_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic                 up_q, up_d;
  logic                 down_q, down_d;
  logic                 err_q, err_d;

  logic [2:0] word_bin;
  logic [2:0] diff;
  logic [3:0] consec_inc;

  assign word_bin   = {bus.g0_in, bus.g0_in ^ bus.g1_in, bus.g0_in ^ bus.g1_in ^ bus.g2_in};
  assign diff       = word_bin - ref_q;
  assign consec_inc = consec_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    consec_d = consec_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    up_d     = 1'b0;
    down_d   = 1'b0;
    err_d    = 1'b0;

    if (bus.clear_in) begin
      // Word is dropped; the decoded outputs keep their last value.
      state_d  = StIdle;
      consec_d = '0;
      cnt_d    = '0;
    end else if (bus.valid_in) begin
      valid_d = 1'b1;
      ref_d   = word_bin;
      if (state_q == StIdle) begin
        state_d  = StTrack;
        consec_d = '0;
      end else begin
        unique case (diff)
          3'd0: ;
          3'd1: begin
            up_d     = 1'b1;
            consec_d = '0;
          end
          3'd7: begin
            down_d   = 1'b1;
            consec_d = '0;
          end
          default: begin
            err_d    = 1'b1;
            cnt_d    = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
            consec_d = consec_inc;
            if (consec_inc == LockLoss) begin
              state_d  = StIdle;
              consec_d = '0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= StIdle;
      ref_q    <= '0;
      consec_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      consec_q <= consec_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      up_q     <= up_d;
      down_q   <= down_d;
      err_q    <= err_d;
    end
  end

  // The held reference is exactly the last decoded word, so it drives b*_out directly.
  assign bus.b0_out      = ref_q[2];
  assign bus.b1_out      = ref_q[1];
  assign bus.b2_out      = ref_q[0];
  assign bus.valid_out   = valid_q;
  assign bus.up_out      = up_q;
  assign bus.down_out    = down_q;
  assign bus.err_out     = err_q;
  assign bus.err_cnt_out = cnt_q;
  assign bus.locked_out  = (state_q == StTrack);

endmodule

// File: tb/tb_gray_step_checker.sv
// Bench for gray_step_checker: directed vector table, saturation sequence and
// randomized stream, on two parameterisations driven with identical stimulus.
module tb_gray_step_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_step_checker_if #(.ERR_CNT_W(8)) if_a ();
  gray_step_checker_if #(.ERR_CNT_W(2)) if_b ();

  gray_step_checker #(.ERR_CNT_W(8), .LOCK_LOSS(3)) dut_a (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (if_a)
  );

  gray_step_checker #(.ERR_CNT_W(2), .LOCK_LOSS(15)) dut_b (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (if_b)
  );

  // {b[2:0], valid, up, down, err, locked}
  logic [7:0] obs [2];
  logic [7:0] cnt_obs [2];
  assign obs[0] = {if_a.b0_out, if_a.b1_out, if_a.b2_out, if_a.valid_out, if_a.up_out,
                   if_a.down_out, if_a.err_out, if_a.locked_out};
  assign obs[1] = {if_b.b0_out, if_b.b1_out, if_b.b2_out, if_b.valid_out, if_b.up_out,
                   if_b.down_out, if_b.err_out, if_b.locked_out};
  assign cnt_obs[0] = if_a.err_cnt_out;
  assign cnt_obs[1] = {6'b0, if_b.err_cnt_out};

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model, one per instance.
  int lock_loss [2] = '{3, 15};
  int cnt_max   [2] = '{255, 3};
  bit m_has_ref [2];
  int m_ref     [2];
  int m_consec  [2];
  int m_cnt     [2];
  logic [7:0] m_exp [2];

  function automatic int gray_to_bin(logic [2:0] g);
    int b2, b1, b0;
    b2 = int'(g[2]);
    b1 = b2 ^ int'(g[1]);
    b0 = b1 ^ int'(g[0]);
    return b2 * 4 + b1 * 2 + b0;
  endfunction

  function automatic logic [2:0] bin_to_gray(int b);
    logic [2:0] bb;
    bb = 3'(b);
    return bb ^ (bb >> 1);
  endfunction

  task automatic model_step(int k, bit r, bit clr, bit vld, logic [2:0] g);
    int nb, d;
    bit v, up, dn, er;
    v = 0; up = 0; dn = 0; er = 0;
    if (r) begin
      m_has_ref[k] = 0; m_ref[k] = 0; m_consec[k] = 0; m_cnt[k] = 0;
    end else if (clr) begin
      m_has_ref[k] = 0; m_consec[k] = 0; m_cnt[k] = 0;
    end else if (vld) begin
      nb = gray_to_bin(g);
      v  = 1;
      if (!m_has_ref[k]) begin
        m_has_ref[k] = 1;
        m_consec[k]  = 0;
      end else begin
        d = (nb - m_ref[k] + 8) % 8;
        if (d == 1) begin up = 1; m_consec[k] = 0; end
        else if (d == 7) begin dn = 1; m_consec[k] = 0; end
        else if (d != 0) begin
          er = 1;
          if (m_cnt[k] < cnt_max[k]) m_cnt[k]++;
          m_consec[k]++;
          if (m_consec[k] == lock_loss[k]) begin
            m_has_ref[k] = 0;
            m_consec[k]  = 0;
          end
        end
      end
      m_ref[k] = nb;
    end
    m_exp[k] = {3'(m_ref[k]), v, up, dn, er, m_has_ref[k]};
  endtask

  task automatic check_model(int k, string tag);
    n_cmp++;
    if (obs[k] !== m_exp[k] || cnt_obs[k] !== 8'(m_cnt[k])) begin
      n_fail++;
      $display("FAIL %s dut%0d: got b/v/up/dn/err/lock=%b cnt=%0d, want %b cnt=%0d",
               tag, k, obs[k], cnt_obs[k], m_exp[k], m_cnt[k]);
    end
  endtask

  task automatic step(bit r, bit clr, bit vld, logic [2:0] g, string tag);
    @(negedge clk);
    rst = r;
    if_a.clear_in = clr; if_a.valid_in = vld;
    if_a.g0_in = g[2]; if_a.g1_in = g[1]; if_a.g2_in = g[0];
    if_b.clear_in = clr; if_b.valid_in = vld;
    if_b.g0_in = g[2]; if_b.g1_in = g[1]; if_b.g2_in = g[0];
    @(posedge clk);
    model_step(0, r, clr, vld, g);
    model_step(1, r, clr, vld, g);
    #1;
    check_model(0, tag);
    check_model(1, tag);
  endtask

  typedef struct {
    bit         r, clr, vld;
    logic [2:0] g;
    logic [2:0] b;
    bit         v, up, dn, err;
    int         cnt;
    bit         lock;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit clr, bit vld, logic [2:0] g, logic [2:0] b,
                              bit v, bit up, bit dn, bit err, int cnt, bit lock);
    vec_t x;
    x.r = r; x.clr = clr; x.vld = vld; x.g = g; x.b = b;
    x.v = v; x.up = up; x.dn = dn; x.err = err; x.cnt = cnt; x.lock = lock;
    return x;
  endfunction

  initial begin
    logic [7:0] want;
    int sat_cnt [5] = '{1, 2, 3, 3, 3};
    logic [2:0] sat_g [5] = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b010};

    if_a.clear_in = 0; if_a.valid_in = 0; if_a.g0_in = 0; if_a.g1_in = 0; if_a.g2_in = 0;
    if_b.clear_in = 0; if_b.valid_in = 0; if_b.g0_in = 0; if_b.g1_in = 0; if_b.g2_in = 0;

    // Expectations below are for the LOCK_LOSS=3, ERR_CNT_W=8 instance.
    //                 r  clr vld g       b       v  up dn er cnt lock
    vecs.push_back(mk(1, 0, 0, 3'b000, 3'd0, 0, 0, 0, 0, 0, 0));  // reset state
    vecs.push_back(mk(0, 0, 1, 3'b000, 3'd0, 1, 0, 0, 0, 0, 1));  // first word
    vecs.push_back(mk(0, 0, 1, 3'b001, 3'd1, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 3'b011, 3'd2, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 3'b010, 3'd3, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 3'b110, 3'd4, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 3'b111, 3'd5, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 3'b101, 3'd6, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 3'b100, 3'd7, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 3'b000, 3'd0, 1, 1, 0, 0, 0, 1));  // wrap 7->0 up
    vecs.push_back(mk(0, 0, 1, 3'b100, 3'd7, 1, 0, 1, 0, 0, 1));  // 0->7 down
    vecs.push_back(mk(0, 0, 1, 3'b101, 3'd6, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 3'b100, 3'd7, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 3'b000, 3'd0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 3'b010, 3'd3, 1, 0, 0, 1, 1, 1));  // illegal 0->3
    vecs.push_back(mk(0, 0, 0, 3'b111, 3'd3, 0, 0, 0, 0, 1, 1));  // idle cycle holds
    vecs.push_back(mk(0, 0, 1, 3'b110, 3'd4, 1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 3'b000, 3'd4, 0, 0, 0, 0, 0, 0));  // clear
    vecs.push_back(mk(0, 0, 1, 3'b000, 3'd0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 3'b010, 3'd3, 1, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 3'b101, 3'd6, 1, 0, 0, 1, 2, 1));
    vecs.push_back(mk(0, 0, 1, 3'b001, 3'd1, 1, 0, 0, 1, 3, 0));  // lock lost
    vecs.push_back(mk(0, 0, 1, 3'b001, 3'd1, 1, 0, 0, 0, 3, 1));  // recapture
    vecs.push_back(mk(0, 1, 1, 3'b011, 3'd1, 0, 0, 0, 0, 0, 0));  // clear beats valid
    vecs.push_back(mk(0, 0, 1, 3'b011, 3'd2, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 3'b010, 3'd3, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 3'b110, 3'd0, 0, 0, 0, 0, 0, 0));  // mid-stream reset
    vecs.push_back(mk(0, 0, 1, 3'b000, 3'd0, 1, 0, 0, 0, 0, 1));  // no err vs old ref

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].clr, vecs[i].vld, vecs[i].g, $sformatf("vec%0d", i));
      want = {vecs[i].b, vecs[i].v, vecs[i].up, vecs[i].dn, vecs[i].err, vecs[i].lock};
      n_cmp++;
      if (obs[0] !== want || cnt_obs[0] !== 8'(vecs[i].cnt)) begin
        n_fail++;
        $display("FAIL table%0d: got b/v/up/dn/err/lock=%b cnt=%0d, want %b cnt=%0d",
                 i, obs[0], cnt_obs[0], want, vecs[i].cnt);
      end
    end

    // Saturation on the 2-bit counter instance.
    step(1, 0, 0, 3'b000, "sat_rst");
    step(0, 0, 1, 3'b000, "sat_first");
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, sat_g[i], $sformatf("sat%0d", i));
      n_cmp++;
      if (if_b.err_out !== 1'b1 || if_b.err_cnt_out !== 2'(sat_cnt[i])) begin
        n_fail++;
        $display("FAIL sat%0d: got err=%b cnt=%0d, want err=1 cnt=%0d",
                 i, if_b.err_out, if_b.err_cnt_out, sat_cnt[i]);
      end
    end

    // Randomized stream, biased toward legal steps so lock is held for long runs.
    for (int i = 0; i < 600; i++) begin
      int r_sel;
      bit r_rst, r_clr, r_vld;
      logic [2:0] r_g;
      int pick;
      r_sel = $urandom_range(0, 99);
      r_rst = (r_sel < 2);
      r_clr = (r_sel >= 2 && r_sel < 6);
      r_vld = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 6) begin
        pick = $urandom_range(0, 2);
        r_g  = bin_to_gray((m_ref[0] + (pick == 0 ? 0 : (pick == 1 ? 1 : 7))) % 8);
      end else begin
        r_g = 3'($urandom_range(0, 7));
      end
      step(r_rst, r_clr, r_vld, r_g, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
